cache_lookup_ctrl: RTL and testbench
====================================

Name: cache_lookup_ctrl

Overview:
- Lookup, hit-detect and miss/refill controller for one odd/even half of the instruction/data cache.
- Drives the tag RAM read index and compares the returned virtual tags against the request address.
- Keeps per-line valid bits and tree pseudo-LRU state.
- On a miss it issues a line-fill handshake downstream, then writes the new tag into the tag RAM write port.

Parameters:
- LINES, 64, lines per way; power of 2.
- WAYS, 4, associativity; fixed at 4 (elaboration error otherwise).
- LOBIT, 6, low bit of the line index.
- HIBIT, $clog2(LINES)-1+LOBIT, high bit of the line index.
- TAGBIT, HIBIT+2, low bit of the tag. Bit HIBIT+1 selects the odd/even half and is excluded from compare.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_i  in  1  lookup request
- rdy_o  out  1  lookup accepted this cycle (IDLE and not rst)
- vadr_i  in  address_t  request virtual address
- padr_i  in  address_t  translated physical address, same cycle as vadr_i
- ndx_o  out  $clog2(LINES)  = vadr_i[HIBIT:LOBIT], combinational, to tag RAM read index
- tag_i  in  cache_tag_t[WAYS]  virtual tags from tag RAM at ndx_o, zero latency
- resp_v_o  out  1  lookup result valid
- hit_o  out  1  lookup hit
- hit_way_o  out  2  hitting way
- multi_hit_o  out  1  more than one way matched (error flag)
- fill_req_o  out  1  line-fill request
- fill_adr_o  out  address_t  padr with bits [LOBIT-1:0] zeroed
- fill_ack_i  in  1  fill complete
- tag_wr_o  out  1  tag RAM write strobe
- tag_way_o  out  2  way to write
- tag_vadr_o  out  address_t  held miss vadr, to tag RAM write address/data
- tag_padr_o  out  address_t  held miss padr, to tag RAM write data
- inv_all_i  in  1  invalidate all lines
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async): all outputs 0, all valid bits 0, PLRU bits 0, state IDLE.
- States: IDLE, FILL, TAGWR.
- IDLE, cycle N, req_i & rdy_o:
  - match[w] = valid[ndx][w] & (tag_i[w] == vadr_i[MSB:TAGBIT]).
  - N+1: resp_v_o=1 for one cycle; hit_o = |match; hit_way_o = lowest matching way; multi_hit_o = popcount(match)>1.
  - Hit: PLRU[ndx] updated at the N edge; state stays IDLE; back-to-back lookups allowed.
  - Miss: latch vadr/padr/victim at the N edge; state -> FILL at N+1.
  - Victim: lowest invalid way, else PLRU victim.
- PLRU per line, bits b0,b1,b2:
  - Victim = b0 ? (b2 ? 3 : 2) : (b1 ? 1 : 0).
  - Access way w sets b0 = (w<2). If w<2, b1 = (w==0); else b2 = (w==2).
- FILL: fill_req_o=1 and fill_adr_o stable until the cycle fill_ack_i=1 (sampled with fill_req_o); next state TAGWR. Ack in the first FILL cycle is legal.
- TAGWR, one cycle:
  - tag_wr_o=1, tag_way_o = victim.
  - At the edge: valid[idx][victim]=1 and PLRU access(victim), unless stale flag set.
  - Next state IDLE; rdy_o=1 the following cycle.
- rdy_o=0 in FILL/TAGWR; req_i ignored (no response).
- inv_all_i:
  - Clears all valid bits at the edge.
  - If state != IDLE, sets stale flag; TAGWR still pulses tag_wr_o but does not set valid. Flag clears on return to IDLE.
  - inv_all_i coincident with an IDLE lookup: that lookup responds miss.
- ack arriving with no fill_req_o: ignored.
- rst mid-fill: immediate IDLE, fill_req_o drops, no tag write.

Decomposition:
- Qupls_cache_pkg holds cache_tag_t, the plru3_t typedef and the PLRU victim/update functions.
- QuplsPkg supplies address_t.
- One natural sub-module, cache_plru4: LINES x 3-bit PLRU array with read-victim and update ports.

Test Plan:
- Cold miss, vadr=padr=0x0000_2040 (ndx 1, tag 1), all invalid -> resp miss at N+1; fill_req_o with fill_adr_o=0x0000_2040; ack -> tag_wr_o 1 cycle, tag_way_o=0; relookup with tag_i[0]=1 -> hit_o=1, hit_way_o=0.
- Four misses to ndx 1, tags 1..4 -> ways 0,1,2,3. Fifth miss, tag 5 -> victim way 0. Then hit way 0, and a further miss, tag 6 -> victim way 2.
- tag_i[1]=tag_i[3]=match, both valid -> hit_way_o=1, multi_hit_o=1.
- inv_all_i during FILL, then ack -> tag_wr_o pulses; relookup same address -> miss.
- rst asserted while fill_req_o=1 -> fill_req_o, busy_o, rdy_o go 0 immediately; after release, lookup -> miss.
- req_i held high through FILL/TAGWR -> no resp_v_o until the IDLE cycle after TAGWR; fill_ack_i in first FILL cycle gives 3-cycle turnaround.

Source files
------------

// File: rtl/cache_lookup_ctrl_pkg.sv
// Shared types and pseudo-LRU helpers for the cache lookup/refill controller.
package cache_lookup_ctrl_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] address_t;
  typedef logic [ADDR_W-1:0] cache_tag_t;
  typedef logic [2:0]        plru3_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_TAGWR = 2'd2
  } lookup_state_e;

  // Tree PLRU: bit0 picks the half to evict, bit1/bit2 pick within each half.
  function automatic logic [1:0] plru_victim(input plru3_t p);
    if (p[0]) return p[2] ? 2'd3 : 2'd2;
    else      return p[1] ? 2'd1 : 2'd0;
  endfunction

  function automatic plru3_t plru_access(input plru3_t p, input logic [1:0] w);
    plru3_t r;
    r    = p;
    r[0] = ~w[1];
    if (!w[1]) r[1] = (w == 2'd0);
    else       r[2] = (w == 2'd2);
    return r;
  endfunction

  function automatic logic [1:0] lowest_way(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_lookup_ctrl_plru4.sv
// Per-line 3-bit tree pseudo-LRU state for a 4-way set: victim read and access update.
module cache_plru4
  import cache_lookup_ctrl_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IW    = $clog2(LINES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx_i,
  output logic [1:0]    victim_o,
  input  logic          upd_i,
  input  logic [IW-1:0] upd_idx_i,
  input  logic [1:0]    upd_way_i
);

  plru3_t plru_q [LINES];

  assign victim_o = plru_victim(plru_q[rd_idx_i]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) plru_q[i] <= '0;
    end else if (upd_i) begin
      plru_q[upd_idx_i] <= plru_access(plru_q[upd_idx_i], upd_way_i);
    end
  end

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Lookup, hit detection and miss/refill sequencing for one odd/even half of a 4-way cache.
module cache_lookup_ctrl
  import cache_lookup_ctrl_pkg::*;
#(
  parameter int LINES  = 64,
  parameter int WAYS   = 4,
  parameter int LOBIT  = 6,
  parameter int HIBIT  = $clog2(LINES) - 1 + LOBIT,
  parameter int TAGBIT = HIBIT + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  output logic                     rdy_o,
  input  logic [ADDR_W-1:0]        vadr_i,
  input  logic [ADDR_W-1:0]        padr_i,
  output logic [$clog2(LINES)-1:0] ndx_o,
  input  cache_tag_t [WAYS-1:0]    tag_i,
  output logic                     resp_v_o,
  output logic                     hit_o,
  output logic [1:0]               hit_way_o,
  output logic                     multi_hit_o,
  output logic                     fill_req_o,
  output logic [ADDR_W-1:0]        fill_adr_o,
  input  logic                     fill_ack_i,
  output logic                     tag_wr_o,
  output logic [1:0]               tag_way_o,
  output logic [ADDR_W-1:0]        tag_vadr_o,
  output logic [ADDR_W-1:0]        tag_padr_o,
  input  logic                     inv_all_i,
  output logic                     busy_o
);

  localparam int IW = $clog2(LINES);

  if (WAYS != 4) begin : g_bad_ways
    $error("cache_lookup_ctrl supports WAYS == 4 only");
  end
  if ((1 << IW) != LINES) begin : g_bad_lines
    $error("cache_lookup_ctrl requires LINES to be a power of 2");
  end

  lookup_state_e   state_q, state_d;
  logic [WAYS-1:0] valid_q [LINES];
  address_t        vadr_q, padr_q;
  logic [1:0]      victim_q;
  logic            stale_q;
  logic            resp_v_q, hit_q, multi_q;
  logic [1:0]      hit_way_q;

  logic [WAYS-1:0] match;
  logic [WAYS-1:0] free_ways;
  logic            lookup, hit_any, commit;
  logic [1:0]      match_way, miss_victim, plru_vict;
  logic [IW-1:0]   wr_idx;
  cache_tag_t      req_tag;

  assign ndx_o   = vadr_i[HIBIT:LOBIT];
  assign req_tag = cache_tag_t'(vadr_i >> TAGBIT);
  assign wr_idx  = vadr_q[HIBIT:LOBIT];
  assign lookup  = req_i & rdy_o;

  // An invalidate landing on the lookup cycle makes every way read as empty.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
    assign match[gi]     = valid_q[ndx_o][gi] & ~inv_all_i & (tag_i[gi] == req_tag);
    assign free_ways[gi] = ~valid_q[ndx_o][gi] | inv_all_i;
  end

  assign hit_any     = |match;
  assign match_way   = lowest_way(match);
  assign miss_victim = (|free_ways) ? lowest_way(free_ways) : plru_vict;
  assign commit      = (state_q == ST_TAGWR) & ~stale_q & ~inv_all_i;

  cache_plru4 #(.LINES(LINES), .IW(IW)) u_plru (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (ndx_o),
    .victim_o  (plru_vict),
    .upd_i     ((lookup & hit_any) | commit),
    .upd_idx_i (lookup ? ndx_o : wr_idx),
    .upd_way_i (lookup ? match_way : victim_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (lookup && !hit_any) state_d = ST_FILL;
      ST_FILL:  if (fill_ack_i) state_d = ST_TAGWR;
      ST_TAGWR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vadr_q    <= '0;
      padr_q    <= '0;
      victim_q  <= '0;
      stale_q   <= 1'b0;
      resp_v_q  <= 1'b0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      multi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      resp_v_q <= lookup;
      if (lookup) begin
        hit_q     <= hit_any;
        hit_way_q <= match_way;
        multi_q   <= ($countones(match) > 1);
        if (!hit_any) begin
          vadr_q   <= vadr_i;
          padr_q   <= padr_i;
          victim_q <= miss_victim;
        end
      end
      // A fill that straddles an invalidate must not resurrect its line.
      if (state_d == ST_IDLE)                      stale_q <= 1'b0;
      else if (inv_all_i && state_q != ST_IDLE)    stale_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) valid_q[i] <= '0;
    end else if (inv_all_i) begin
      for (int i = 0; i < LINES; i++) valid_q[i] <= '0;
    end else if (commit) begin
      valid_q[wr_idx][victim_q] <= 1'b1;
    end
  end

  assign rdy_o       = (state_q == ST_IDLE) & ~rst;
  assign busy_o      = (state_q != ST_IDLE);
  assign resp_v_o    = resp_v_q;
  assign hit_o       = hit_q;
  assign hit_way_o   = hit_way_q;
  assign multi_hit_o = multi_q;
  assign fill_req_o  = (state_q == ST_FILL);
  assign fill_adr_o  = {padr_q[ADDR_W-1:LOBIT], {LOBIT{1'b0}}};
  assign tag_wr_o    = (state_q == ST_TAGWR);
  assign tag_way_o   = victim_q;
  assign tag_vadr_o  = vadr_q;
  assign tag_padr_o  = padr_q;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Randomized and directed bench for cache_lookup_ctrl with a queue-based scoreboard.
module tb_cache_lookup_ctrl;
  import cache_lookup_ctrl_pkg::*;

  localparam int LINES  = 64;
  localparam int LOBIT  = 6;
  localparam int TAGBIT = 13;

  logic clk, rst, req_i, rdy_o, fill_ack_i, inv_all_i;
  address_t vadr_i, padr_i, fill_adr_o, tag_vadr_o, tag_padr_o;
  logic [5:0] ndx_o;
  cache_tag_t [3:0] tag_i;
  logic resp_v_o, hit_o, multi_hit_o, fill_req_o, tag_wr_o, busy_o;
  logic [1:0] hit_way_o, tag_way_o;

  cache_lookup_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req_i), .rdy_o(rdy_o), .vadr_i(vadr_i), .padr_i(padr_i),
    .ndx_o(ndx_o), .tag_i(tag_i), .resp_v_o(resp_v_o), .hit_o(hit_o), .hit_way_o(hit_way_o),
    .multi_hit_o(multi_hit_o), .fill_req_o(fill_req_o), .fill_adr_o(fill_adr_o),
    .fill_ack_i(fill_ack_i), .tag_wr_o(tag_wr_o), .tag_way_o(tag_way_o),
    .tag_vadr_o(tag_vadr_o), .tag_padr_o(tag_padr_o), .inv_all_i(inv_all_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side tag RAM and the reference view of cache contents.
  cache_tag_t tram [LINES][4];
  bit [3:0]   m_valid [LINES];
  bit [2:0]   m_plru  [LINES];
  bit         ovr_en;
  cache_tag_t ovr [4];

  always_comb begin
    for (int w = 0; w < 4; w++)
      tag_i[w] = ovr_en ? ovr[w] : tram[int'((vadr_i >> LOBIT) & 32'h3F)][w];
  end

  typedef struct { bit hit; int way; bit multi; } resp_t;
  typedef struct { address_t fadr; address_t vadr; address_t padr; int way; } fill_t;
  resp_t rq[$];
  fill_t fq[$];

  // Spec-level PLRU: b0 says "evict from the upper pair", b1/b2 pick inside each pair.
  function automatic int m_victim(input bit [2:0] b);
    return b[0] ? (2 + int'(b[2])) : int'(b[1]);
  endfunction

  function automatic bit [2:0] m_touch(input bit [2:0] b, input int w);
    bit [2:0] r = b;
    r[0] = (w < 2);
    if (w < 2) r[1] = (w == 0);
    else       r[2] = (w == 2);
    return r;
  endfunction

  function automatic void m_clear_valid();
    for (int i = 0; i < LINES; i++) m_valid[i] = '0;
  endfunction

  // Monitor: pops and compares whenever the DUT presents a result.
  resp_t mon_r;
  fill_t mon_f;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (resp_v_o) begin
        if (rq.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          mon_r = rq.pop_front();
          chk("hit", hit_o, mon_r.hit);
          if (mon_r.hit) chk("hit_way", hit_way_o, mon_r.way);
          chk("multi_hit", multi_hit_o, mon_r.multi);
        end
      end
      if (fill_req_o) begin
        if (fq.size() == 0) chk("fill_unexpected", 1, 0);
        else chk("fill_adr", fill_adr_o, fq[0].fadr);
      end
      if (tag_wr_o) begin
        if (fq.size() == 0) chk("tagwr_unexpected", 1, 0);
        else begin
          mon_f = fq.pop_front();
          chk("tag_way", tag_way_o, mon_f.way);
          chk("tag_vadr", tag_vadr_o, mon_f.vadr);
          chk("tag_padr", tag_padr_o, mon_f.padr);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_i = 0; fill_ack_i = 0; inv_all_i = 0;
    #1;
    chk("rst_rdy", rdy_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_fill_req", fill_req_o, 0);
    chk("rst_tag_wr", tag_wr_o, 0);
    chk("rst_fill_adr", fill_adr_o, 0);
    m_clear_valid();
    for (int i = 0; i < LINES; i++) m_plru[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_rdy", rdy_o, 1);
  endtask

  // One lookup and, on a miss, the whole refill. way_r/hit_r report what the DUT did.
  task automatic lookup(input address_t v, input address_t p, input int ack_dly,
                        input bit inv_fill, input bit inv_req, input bit hold, input bit rst_fill,
                        output int way_r, output bit hit_r);
    int nd = int'((v >> LOBIT) & 32'h3F);
    cache_tag_t t = cache_tag_t'(v >> TAGBIT);
    bit [3:0] m;
    int way, vic;
    bit stale = 0;
    resp_t r;
    fill_t f;
    @(negedge clk);
    vadr_i = v; padr_i = p; req_i = 1'b1; inv_all_i = inv_req;
    fill_ack_i = ($urandom_range(0, 3) == 0);
    #1;
    chk("rdy_idle", rdy_o, 1);
    chk("ndx", ndx_o, nd);
    for (int w = 0; w < 4; w++)
      m[w] = m_valid[nd][w] && !inv_req && ((ovr_en ? ovr[w] : tram[nd][w]) == t);
    way = 0;
    for (int w = 3; w >= 0; w--) if (m[w]) way = w;
    r.hit = (m != 0); r.way = way; r.multi = ($countones(m) > 1);
    rq.push_back(r);
    if (inv_req) m_clear_valid();
    if (r.hit) begin
      m_plru[nd] = m_touch(m_plru[nd], way);
    end else begin
      vic = -1;
      for (int w = 3; w >= 0; w--) if (!m_valid[nd][w]) vic = w;
      if (vic < 0) vic = m_victim(m_plru[nd]);
      f.fadr = p & ~32'h3F; f.vadr = v; f.padr = p; f.way = vic;
      fq.push_back(f);
    end
    @(posedge clk); #1;
    inv_all_i = 0; fill_ack_i = 0;
    if (!hold) req_i = 0;
    hit_r = hit_o; way_r = int'(hit_way_o);
    if (r.hit) return;
    chk("fill_busy", busy_o, 1);
    chk("fill_rdy", rdy_o, 0);
    if (rst_fill) begin
      rst = 1'b1;
      #1;
      chk("rstfill_req", fill_req_o, 0);
      chk("rstfill_busy", busy_o, 0);
      chk("rstfill_rdy", rdy_o, 0);
      void'(fq.pop_front());
      m_clear_valid();
      for (int i = 0; i < LINES; i++) m_plru[i] = '0;
      @(negedge clk);
      rst = 1'b0; req_i = 0;
      return;
    end
    if (inv_fill) begin
      inv_all_i = 1'b1;
      @(posedge clk); #1;
      inv_all_i = 0;
      m_clear_valid();
      stale = 1;
    end
    for (int i = 0; i < ack_dly; i++) begin
      @(posedge clk); #1;
      chk("fill_hold", fill_req_o, 1);
    end
    fill_ack_i = 1'b1;
    @(posedge clk); #1;
    fill_ack_i = 0;
    chk("tagwr_pulse", tag_wr_o, 1);
    chk("tagwr_rdy", rdy_o, 0);
    way_r = int'(tag_way_o);
    tram[nd][vic] = t;
    if (!stale) begin
      m_valid[nd][vic] = 1'b1;
      m_plru[nd] = m_touch(m_plru[nd], vic);
    end
    @(posedge clk); #1;
    chk("after_tagwr_wr", tag_wr_o, 0);
    chk("after_tagwr_rdy", rdy_o, 1);
    chk("after_tagwr_busy", busy_o, 0);
    req_i = 0;
  endtask

  function automatic address_t mk(input int tag, input int nd);
    return address_t'((tag << TAGBIT) | (nd << LOBIT));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int way;
    bit hit;
    address_t a;
    rst = 1; req_i = 0; fill_ack_i = 0; inv_all_i = 0; vadr_i = 0; padr_i = 0; ovr_en = 0;
    for (int i = 0; i < LINES; i++)
      for (int w = 0; w < 4; w++) tram[i][w] = '0;
    for (int w = 0; w < 4; w++) ovr[w] = '0;
    do_reset();

    // Cold miss then refetch.
    lookup(32'h0000_2040, 32'h0000_2040, 2, 0, 0, 0, 0, way, hit);
    chk("cold_miss", hit, 0);
    chk("cold_way", way, 0);
    lookup(32'h0000_2040, 32'h0000_2040, 0, 0, 0, 0, 0, way, hit);
    chk("cold_rehit", hit, 1);
    chk("cold_rehit_way", way, 0);

    // Fill a set, then exercise PLRU replacement.
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      lookup(mk(t, 1), mk(t, 1) | 32'h1000_0000, 1, 0, 0, 0, 0, way, hit);
      chk("fill_order_way", way, t - 1);
    end
    lookup(mk(5, 1), mk(5, 1), 1, 0, 0, 0, 0, way, hit);
    chk("plru_victim_t5", way, 0);
    lookup(mk(5, 1), mk(5, 1), 0, 0, 0, 0, 0, way, hit);
    chk("plru_hit_t5", hit, 1);
    chk("plru_hit_t5_way", way, 0);
    lookup(mk(6, 1), mk(6, 1), 1, 0, 0, 0, 0, way, hit);
    chk("plru_victim_t6", way, 2);

    // Two ways matching.
    ovr_en = 1;
    ovr[0] = 32'd99; ovr[1] = 32'd7; ovr[2] = 32'd98; ovr[3] = 32'd7;
    lookup(mk(7, 1), mk(7, 1), 0, 0, 0, 0, 0, way, hit);
    chk("multi_hit_way", way, 1);
    ovr_en = 0;

    // Invalidate during FILL: tag still written, line not valid.
    a = mk(9, 5);
    lookup(a, a, 2, 1, 0, 0, 0, way, hit);
    lookup(a, a, 1, 0, 0, 0, 0, way, hit);
    chk("stale_relookup_miss", hit, 0);
    lookup(a, a, 0, 0, 0, 0, 0, way, hit);
    chk("stale_refill_hit", hit, 1);

    // Invalidate coincident with a lookup that would hit.
    lookup(a, a, 1, 0, 1, 0, 0, way, hit);
    chk("inv_req_miss", hit, 0);

    // Reset in the middle of a fill.
    a = mk(3, 9);
    lookup(a, a, 0, 0, 0, 0, 1, way, hit);
    lookup(a, a, 0, 0, 0, 0, 0, way, hit);
    chk("post_rstfill_miss", hit, 0);

    // req held high through the refill, ack on the first FILL cycle.
    a = mk(11, 12);
    lookup(a, a, 0, 0, 0, 1, 0, way, hit);
    lookup(a, a, 0, 0, 0, 0, 0, way, hit);
    chk("hold_rehit", hit, 1);

    // Randomized traffic over a few sets.
    for (int i = 0; i < 200; i++) begin
      a = mk($urandom_range(1, 6), $urandom_range(1, 3)) | ($urandom_range(0, 1) << 12)
          | $urandom_range(0, 63);
      lookup(a, $urandom, $urandom_range(0, 3), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 15) == 0), 0, 0, way, hit);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("resp_queue_drained", rq.size(), 0);
    chk("fill_queue_drained", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
